m_axis_out_fifo: RTL
====================

// Module: m_axis_out_fifo
// PURPOSE
//  Parametrised AXI4-Stream master output FIFO; successor to the single-width video output stage.
//  Write side is a simple push port (wr_en/full) driven by the crop datapath.
//  Read side is an AXIS master with a registered output stage, configurable TUSER/TKEEP widths,
//  almost-full/fill-level reporting, a sticky overflow flag, and an optional store-and-forward packet mode.
// PARAMETERS
//  DATA_W      32   TDATA width in bits; multiple of 8.
//  USER_W      1    TUSER width in bits; bit0 = start-of-frame.
//  DEPTH       16   RAM entries; power of two, >= 4.
//  AFULL_THR   12   almost_full asserts when fill_level >= AFULL_THR; 1..DEPTH.
// PORTS
//  M_AXIS_ACLK     in   1            clock
//  M_AXIS_ARESETN  in   1            asynchronous active-low reset
//  wr_en           in   1            push request
//  data_in         in   DATA_W       push data
//  last_in         in   1            push end-of-line
//  user_in         in   USER_W       push user sideband
//  full            out  1            RAM holds DEPTH entries
//  almost_full     out  1            fill_level >= AFULL_THR
//  fill_level      out  AW+1         RAM occupancy 0..DEPTH (AW = $clog2(DEPTH))
//  overflow        out  1            sticky: wr_en seen while full
//  ovf_clr         in   1            clears overflow
//  M_AXIS_TDATA    out  DATA_W       stream data
//  M_AXIS_TKEEP    out  DATA_W/8     constant all-ones
//  M_AXIS_TVALID   out  1            stream valid
//  M_AXIS_TREADY   in   1            stream ready
//  M_AXIS_TLAST    out  1            stream last
//  M_AXIS_TUSER    out  USER_W       stream user
// BEHAVIOUR
//  Reset (async assert, sync deassert): pointers/fill_level=0, TVALID=0, TDATA/TLAST/TUSER=0, overflow=0.
//  Push: accepted iff wr_en && !full; written at that edge. wr_en && full -> dropped, overflow<=1.
//  Pointers AW+1 bits with wrap bit; full = (wr_ptr^rd_ptr)=={1,0..0}; wrap at DEPTH is natural.
//  Output register load (pop) when RAM non-empty && (!TVALID || TREADY) && pop_allowed.
//  No pop and TVALID && TREADY -> TVALID<=0. TDATA/TLAST/TUSER stable while TVALID && !TREADY.
//  Latency: push accepted at edge N into empty FIFO -> TVALID high after edge N+1.
//  Throughput: 1 beat/cycle sustained with TREADY=1; push and pop in same cycle leave fill_level unchanged.
//  Push while full is not accepted even if a pop occurs that cycle (no pass-through).
//  fill_level counts RAM only (excludes the output register); max total storage DEPTH+1 beats.
//  ovf_clr and a new overflow in the same cycle -> overflow stays 1.
// CONFIGURATION
//  M_AXIS_OUT_FIFO_PKT_MODE_EN defined: store-and-forward. pkt_cnt counts complete lines in RAM
//   (+1 on push with last_in, -1 on pop of a last entry; simultaneous -> unchanged).
//   pop_allowed = (pkt_cnt != 0) || full || draining; draining set on a pop with last=0, cleared on a pop with last=1.
//   Line longer than DEPTH therefore degrades to cut-through instead of deadlocking.
//  Undefined: cut-through; pop_allowed = 1; no pkt_cnt logic synthesised.
// STRUCTURE
//  Package m_axis_fifo_pkg: function clog2-based ADDR_W, entry struct/packing {user,last,data}, localparam ENTRY_W.
//  Sub-module axis_fifo_ram: simple dual-port RAM, ENTRY_W x DEPTH, sync write, async read.
//  Top holds pointers, fill/flag logic, output register, optional packet counter.
// TESTING
//  1 Push 0xA0..0xA3 (last on 0xA3), TREADY=1 -> TVALID after N+1, beats in order, TLAST only on 0xA3.
//  2 TREADY=0, push 20 beats (DEPTH=16) -> full after 17 accepted (16 RAM + 1 out reg), overflow=1, almost_full at 12.
//  3 Toggle TREADY randomly 1000 beats -> TDATA never changes while TVALID && !TREADY; no loss/dup.
//  4 Simultaneous push+pop at fill_level=16 and 0 -> push rejected at 16; at 0 fill stays consistent.
//  5 Assert ARESETN low mid-burst -> TVALID=0 immediately, fill_level=0; post-reset stream starts clean.
//  6 PKT_MODE_EN: push 3 beats no last -> TVALID stays 0; push last -> 4 beats emerge back-to-back.

Source files
------------

// File: rtl/m_axis_fifo_pkg.sv
// Shared helpers for the AXI4-Stream output FIFO: address width and
// packed entry width ({user, last, data}) derived from the top parameters.
package m_axis_fifo_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_USER_W = 1;

  // Address bits needed to index DEPTH entries (pointers carry one extra wrap bit).
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Stored entry is {user, last, data}.
  function automatic int unsigned entry_w(input int unsigned data_w, input int unsigned user_w);
    return user_w + 1 + data_w;
  endfunction

  localparam int unsigned ENTRY_W = entry_w(DEF_DATA_W, DEF_USER_W);

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for the output FIFO: synchronous write, asynchronous read.
module axis_fifo_ram #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: one entry per accepted push.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/m_axis_out_fifo.sv
// AXI4-Stream master output FIFO with registered output stage, fill-level /
// almost-full reporting and a sticky overflow flag.
// Define M_AXIS_OUT_FIFO_PKT_MODE_EN for store-and-forward packet mode;
// left undefined the FIFO runs cut-through.
module m_axis_out_fifo
  import m_axis_fifo_pkg::*;
#(
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned USER_W    = 1,
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned AFULL_THR = 12,
  localparam int unsigned AW        = addr_w(DEPTH)
) (
  input  logic                M_AXIS_ACLK,
  input  logic                M_AXIS_ARESETN,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                last_in,
  input  logic [USER_W-1:0]   user_in,
  output logic                full,
  output logic                almost_full,
  output logic [AW:0]         fill_level,
  output logic                overflow,
  input  logic                ovf_clr,
  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY,
  output logic                M_AXIS_TLAST,
  output logic [USER_W-1:0]   M_AXIS_TUSER
);

  localparam int unsigned EW        = entry_w(DATA_W, USER_W);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] FULL_XOR  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THR);

  typedef struct packed {
    logic [USER_W-1:0] user;
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic [USER_W-1:0] tuser_q, tuser_d;
  logic              ovf_q, ovf_d;

  logic              full_w, empty_w, push, pop, pop_allowed;
  logic [AW:0]       fill_w;
  entry_t            wr_entry, rd_entry;
  logic [EW-1:0]     rd_word;

  assign full_w  = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign fill_w  = wr_ptr_q - rd_ptr_q;

  // A push into a full RAM is dropped even if a pop frees a slot the same cycle.
  assign push = wr_en && !full_w;
  assign pop  = !empty_w && (!tvalid_q || M_AXIS_TREADY) && pop_allowed;

  assign wr_entry = '{user: user_in, last: last_in, data: data_in};
  assign rd_entry = entry_t'(rd_word);

  axis_fifo_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (M_AXIS_ACLK),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_word)
  );

`ifdef M_AXIS_OUT_FIFO_PKT_MODE_EN
  logic [AW:0] pkt_cnt_q;
  logic        draining_q;
  logic        pkt_inc, pkt_dec;

  assign pkt_inc = push && last_in;
  assign pkt_dec = pop && rd_entry.last;

  // Complete lines in RAM gate popping; a full RAM or a line already in flight
  // keeps the stream moving so over-long lines fall back to cut-through.
  assign pop_allowed = (pkt_cnt_q != '0) || full_w || draining_q;

  // Line counter and mid-line draining flag.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      pkt_cnt_q  <= '0;
      draining_q <= 1'b0;
    end else begin
      if (pkt_inc && !pkt_dec)      pkt_cnt_q <= pkt_cnt_q + PTR_ONE;
      else if (!pkt_inc && pkt_dec) pkt_cnt_q <= pkt_cnt_q - PTR_ONE;
      if (pop) draining_q <= !rd_entry.last;
    end
  end
`else
  assign pop_allowed = 1'b1;
`endif

  // Next-state for pointers, output register and overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      tvalid_d = 1'b1;
      tdata_d  = rd_entry.data;
      tlast_d  = rd_entry.last;
      tuser_d  = rd_entry.user;
    end else if (tvalid_q && M_AXIS_TREADY) begin
      tvalid_d = 1'b0;
    end
    if (wr_en && full_w) ovf_d = 1'b1;
    else if (ovf_clr)    ovf_d = 1'b0;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      ovf_q    <= ovf_d;
    end
  end

  assign full          = full_w;
  assign fill_level    = fill_w;
  assign almost_full   = (fill_w >= AFULL_LVL);
  assign overflow      = ovf_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TKEEP  = '1;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TUSER  = tuser_q;

endmodule
